icache_fetch_port: RTL and testbench

Fetch-side adapter between the frontend fetch stage and the instruction cache, speaking the core-to-icache req/gnt/addr/rdata/rsp protocol on its cache side. It accepts fetch-block requests at arbitrary byte addresses and splits any fetch that crosses a cacheline into two line-aligned cache requests. It tracks up to `MAX_OUTSTANDING` fetches in order, merges the one or two returned lines, and emits the extracted fetch block. A flush input discards all in-flight work, including responses still owed by the cache.

---
 rtl/icache_fetch_port.sv | 226 ++++++++++++++++++++++
 tb/tb_icache_fetch_port.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_port.sv
// Fetch-side adapter: splits line-crossing fetches into two line requests and merges the returned lines.
// Optional feature macro: ICACHE_FETCH_SPLIT_EN (enables two-request handling of line-crossing fetches).
module icache_fetch_port #(
    parameter int ADDR_W          = 64,
    parameter int LINE_BYTES      = 64,
    parameter int FETCH_BYTES     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     f_req,
    output logic                     f_gnt,
    input  logic [ADDR_W-1:0]        f_addr,
    input  logic                     flush,
    output logic                     c_req,
    input  logic                     c_gnt,
    output logic [ADDR_W-1:0]        c_addr,
    input  logic [LINE_BYTES*8-1:0]  c_rdata,
    input  logic                     c_rsp,
    output logic                     o_vld,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [FETCH_BYTES*8-1:0] o_data
);

    localparam int OFF_W   = $clog2(LINE_BYTES);
    localparam int IDX_W   = $clog2(MAX_OUTSTANDING);
    localparam int PTR_W   = IDX_W + 1;
    localparam int CNT_W   = $clog2(2 * MAX_OUTSTANDING) + 1;
    localparam int LINE_W  = LINE_BYTES * 8;
    localparam int FETCH_W = FETCH_BYTES * 8;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1} state_t;

    state_t              state, state_nxt;
    logic                c_req_nxt;
    logic [ADDR_W-1:0]   c_addr_nxt;
    logic                req_cross, req_cross_nxt;
    logic                push;
    logic                f_cross;

    logic [ADDR_W-1:0]   trk_addr [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                full, empty;

    logic [ADDR_W-1:0]   head_addr;
    logic [OFF_W-1:0]    head_off;
    logic                head_cross;
    logic                rsp_live;
    logic                complete;
    logic [LINE_W-1:0]   first_half, second_half;
    logic [FETCH_W-1:0]  fetch_data;

    logic [CNT_W-1:0]    inflight, inflight_nxt, discard_cnt;
    logic                grant;

`ifdef ICACHE_FETCH_SPLIT_EN
    localparam logic [OFF_W:0] FETCH_SZ = (OFF_W + 1)'(FETCH_BYTES);
    localparam logic [OFF_W:0] LINE_SZ  = (OFF_W + 1)'(LINE_BYTES);

    logic                trk_cross [MAX_OUTSTANDING];
    logic [LINE_W-1:0]   line0;
    logic                first_seen;
    logic                capture;
    logic [OFF_W-1:0]    f_off;

    assign f_off   = f_addr[OFF_W-1:0];
    assign f_cross = ({1'b0, f_off} + FETCH_SZ) > LINE_SZ;
`else
    assign f_cross = 1'b0;
`endif

    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign f_gnt = rst_n && !flush && (state == IDLE) && !full;
    assign grant = c_req && c_gnt;

    // Issue FSM; c_req/c_addr are registered and held until granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            c_req     <= 1'b0;
            c_addr    <= '0;
            req_cross <= 1'b0;
        end else begin
            state     <= state_nxt;
            c_req     <= c_req_nxt;
            c_addr    <= c_addr_nxt;
            req_cross <= req_cross_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        c_req_nxt     = c_req;
        c_addr_nxt    = c_addr;
        req_cross_nxt = req_cross;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (f_req && f_gnt) begin
                    state_nxt     = ISSUE0;
                    c_req_nxt     = 1'b1;
                    c_addr_nxt    = f_addr & ~LINE_MASK;
                    req_cross_nxt = f_cross;
                    push          = 1'b1;
                end
            end
            ISSUE0: begin
                if (c_gnt) begin
                    if (req_cross) begin
                        state_nxt  = ISSUE1;
                        c_addr_nxt = c_addr + LINE_STEP;
                    end else begin
                        state_nxt = IDLE;
                        c_req_nxt = 1'b0;
                    end
                end
            end
            ISSUE1: begin
                if (c_gnt) begin
                    state_nxt = IDLE;
                    c_req_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                c_req_nxt = 1'b0;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
            c_req_nxt = 1'b0;
            push      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (complete)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            trk_addr[wr_ptr[IDX_W-1:0]]  <= f_addr;
`ifdef ICACHE_FETCH_SPLIT_EN
            trk_cross[wr_ptr[IDX_W-1:0]] <= f_cross;
`endif
        end
    end

    assign head_addr = trk_addr[rd_ptr[IDX_W-1:0]];
    assign head_off  = head_addr[OFF_W-1:0];
    assign rsp_live  = c_rsp && !flush && (discard_cnt == '0) && !empty;

`ifdef ICACHE_FETCH_SPLIT_EN
    assign head_cross = trk_cross[rd_ptr[IDX_W-1:0]];
    assign capture    = rsp_live && head_cross && !first_seen;
    assign complete   = rsp_live && !(head_cross && !first_seen);

    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            first_seen <= 1'b0;
        else if (capture)
            first_seen <= 1'b1;
        else if (complete)
            first_seen <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (capture)
            line0 <= c_rdata;
    end

    assign first_half  = head_cross ? line0 : c_rdata;
    assign second_half = head_cross ? c_rdata : '0;
`else
    assign head_cross  = 1'b0;
    assign complete    = rsp_live;
    assign first_half  = c_rdata;
    assign second_half = '0;
`endif

    // Bytes past the first line come from the second line (or zero when not split).
    assign fetch_data = FETCH_W'({second_half, first_half} >> {head_off, 3'b000});

    assign inflight_nxt = inflight + CNT_W'(grant) - CNT_W'(c_rsp);

    // A grant in the flush cycle still owes a response, so it joins the discard count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (flush)
                discard_cnt <= inflight_nxt;
            else if (c_rsp && (discard_cnt != '0))
                discard_cnt <= discard_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_vld  <= 1'b0;
            o_addr <= '0;
            o_data <= '0;
        end else begin
            o_vld <= complete;
            if (complete) begin
                o_addr <= head_addr;
                o_data <= fetch_data;
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_port.sv
// Scoreboard bench for icache_fetch_port with a behavioural in-order cache model.
// Expected fetch blocks are built byte-by-byte from the cache's address-derived line contents.
module tb_icache_fetch_port;

    localparam int AW = 64;
    localparam int LB = 64;
    localparam int FB = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_req = 1'b0;
    logic              f_gnt;
    logic [AW-1:0]     f_addr = '0;
    logic              flush = 1'b0;
    logic              c_req;
    logic              c_gnt = 1'b0;
    logic [AW-1:0]     c_addr;
    logic [LB*8-1:0]   c_rdata = '0;
    logic              c_rsp = 1'b0;
    logic              o_vld;
    logic [AW-1:0]     o_addr;
    logic [FB*8-1:0]   o_data;

    icache_fetch_port #(
        .ADDR_W(AW),
        .LINE_BYTES(LB),
        .FETCH_BYTES(FB),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .f_req(f_req),
        .f_gnt(f_gnt),
        .f_addr(f_addr),
        .flush(flush),
        .c_req(c_req),
        .c_gnt(c_gnt),
        .c_addr(c_addr),
        .c_rdata(c_rdata),
        .c_rsp(c_rsp),
        .o_vld(o_vld),
        .o_addr(o_addr),
        .o_data(o_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [FB*8-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] pend[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_vld = 0;
    int            gnt_pct = 100;
    int            rsp_pct = 100;
    int            gnt_budget = -1;
    int            rsp_budget = -1;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
        return {a[6], a[7], a[5:0]} ^ {a[11:8], 4'b0000};
    endfunction

    function automatic logic [LB*8-1:0] line_data(input logic [AW-1:0] la);
        logic [LB*8-1:0] d;
        for (int i = 0; i < LB; i++)
            d[i*8 +: 8] = byte_at(la + AW'(i));
        return d;
    endfunction

    function automatic logic [FB*8-1:0] exp_data(input logic [AW-1:0] a);
        logic [FB*8-1:0] d = '0;
        for (int k = 0; k < FB; k++) begin
`ifdef ICACHE_FETCH_SPLIT_EN
            d[k*8 +: 8] = byte_at(a + AW'(k));
`else
            if (int'(a[5:0]) + k < LB)
                d[k*8 +: 8] = byte_at(a + AW'(k));
`endif
        end
        return d;
    endfunction

    // Cache model: answer before recording this cycle's grant so latency is at least one cycle.
    always @(negedge clk) begin
        #1;
        c_rsp = 1'b0;
        if (pend.size() != 0 && rsp_budget != 0 && $urandom_range(0, 99) < rsp_pct) begin
            c_rsp   = 1'b1;
            c_rdata = line_data(pend.pop_front());
            if (rsp_budget > 0) rsp_budget--;
        end
        c_gnt = (gnt_budget != 0) && ($urandom_range(0, 99) < gnt_pct);
        if (c_req && c_gnt) begin
            pend.push_back(c_addr);
            if (gnt_budget > 0) gnt_budget--;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) pend.delete();
    end

    always @(negedge clk) begin
        if (o_vld) begin
            n_vld++;
            if (exp_q.size() == 0) begin
                check_val("spurious_vld", 128'(o_vld), 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("o_addr", 128'(o_addr), 128'(mon_e.addr));
                check_val("o_data", o_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a);
        bit ok = 1'b0;
        f_req  = 1'b1;
        f_addr = a;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (f_gnt) begin
                ok = 1'b1;
                exp_q.push_back('{a, exp_data(a)});
            end
            step();
            if (ok) break;
        end
        f_req = 1'b0;
        if (!ok) check_val("fetch_gnt_timeout", 128'(f_gnt), 128'd1);
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && i < 3000) begin
            step();
            i++;
        end
        if (i >= 3000) check_val("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [AW-1:0] a;

        repeat (3) step();
        #1;
        check_val("rst_c_req", 128'(c_req), 128'd0);
        check_val("rst_c_addr", 128'(c_addr), 128'd0);
        check_val("rst_o_vld", 128'(o_vld), 128'd0);
        check_val("rst_o_addr", 128'(o_addr), 128'd0);
        check_val("rst_o_data", 128'(o_data), 128'd0);
        check_val("rst_f_gnt", 128'(f_gnt), 128'd0);
        rst_n = 1'b1;
        step();

        // aligned fetch, minimum latency
        do_fetch(64'h1008);
        #1;
        check_val("al_c_req", 128'(c_req), 128'd1);
        check_val("al_c_addr", 128'(c_addr), 128'h1000);
        step();
        check_val("al_vld_t2", 128'(o_vld), 128'd0);
        step();
        check_val("al_vld_t3", 128'(o_vld), 128'd1);
        drain();

        // line-crossing fetch
        do_fetch(64'h1038);
        #1;
        check_val("cr_addr0", 128'(c_addr), 128'h1000);
        step();
`ifdef ICACHE_FETCH_SPLIT_EN
        check_val("cr_req1", 128'(c_req), 128'd1);
        check_val("cr_addr1", 128'(c_addr), 128'h1040);
`else
        check_val("cr_req1", 128'(c_req), 128'd0);
`endif
        drain();

        // grant withheld: request held stable
        gnt_budget = 0;
        do_fetch(64'h2004);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("hold_c_req", 128'(c_req), 128'd1);
            check_val("hold_c_addr", 128'(c_addr), 128'h2000);
            check_val("hold_no_grant", 128'(pend.size()), 128'd0);
            step();
        end
        gnt_budget = -1;
        drain();

        // tracker full
        rsp_budget = 0;
        for (int i = 0; i < 4; i++) do_fetch(64'h5000 + AW'(i * 64));
        step();
        #1;
        check_val("full_gnt0", 128'(f_gnt), 128'd0);
        step();
        #1;
        check_val("full_gnt1", 128'(f_gnt), 128'd0);
        rsp_budget = 1;
        step();
        #1;
        check_val("full_rsp_cycle", 128'(f_gnt), 128'd0);
        step();
        #1;
        check_val("full_release", 128'(f_gnt), 128'd1);
        step();
        rsp_budget = -1;
        drain();

        // flush with three unanswered requests plus a grant in the flush cycle
        rsp_budget = 0;
        do_fetch(64'h4000);
        do_fetch(64'h4040);
        do_fetch(64'h4080);
        do_fetch(64'h40c0);
        flush = 1'b1;
        exp_q.delete();
        #1;
        check_val("fl_grant_cycle", 128'(c_req && c_gnt), 128'd1);
        step();
        flush = 1'b0;
        snap = n_vld;
        #1;
        check_val("fl_c_req", 128'(c_req), 128'd0);
        check_val("fl_pending", 128'(pend.size()), 128'd4);
        do_fetch(64'h3010);
        rsp_budget = -1;
        drain();
        check_val("fl_vld_count", 128'(n_vld - snap), 128'd1);

        // reset while a request is outstanding
`ifdef ICACHE_FETCH_SPLIT_EN
        gnt_budget = 1;
`else
        gnt_budget = 0;
`endif
        rsp_budget = 0;
        do_fetch(64'h6038);
`ifdef ICACHE_FETCH_SPLIT_EN
        step();
        check_val("rs_issue1_addr", 128'(c_addr), 128'h6040);
`endif
        check_val("rs_c_req_pre", 128'(c_req), 128'd1);
        rst_n = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        #1;
        check_val("rs_c_req", 128'(c_req), 128'd0);
        check_val("rs_o_vld", 128'(o_vld), 128'd0);
        check_val("rs_f_gnt", 128'(f_gnt), 128'd1);
        gnt_budget = -1;
        rsp_budget = -1;
        step();
        do_fetch(64'h7030);
        drain();

        // address wrap at the top of the address space
        do_fetch(64'hFFFF_FFFF_FFFF_FFF8);
        drain();

        // random traffic with stalls and occasional flushes
        gnt_pct = 70;
        rsp_pct = 60;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                exp_q.delete();
                step();
                flush = 1'b0;
            end
            a = 64'h8000 + AW'($urandom_range(0, 15) * 64) + AW'($urandom_range(0, 63));
            do_fetch(a);
        end
        gnt_pct = 100;
        rsp_pct = 100;
        drain();
        repeat (3) step();
        check_val("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
